fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 88 ++++++++
 tb/tb_fetch_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: walks the PC through memory in ADDR/WAIT/VALID steps,
// presents the fetched word in ir_out until consumed, and accepts redirects.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        run,
  input  logic        ir_ack,
  input  logic        pc_load,
  input  logic [15:0] pc_target,
  input  logic [15:0] mdr_in,
  output logic [15:0] addr_out,
  output logic        memw_out,
  output logic [15:0] ir_out,
  output logic [15:0] pc_out,
  output logic        ir_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt;
  logic        ir_load;

  // A redirect overrides everything, including the WAIT-exit load and ir_ack.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_load   = 1'b0;
    if (pc_load) begin
      state_nxt = ADDR;
      pc_nxt    = pc_target;
    end else begin
      case (state)
        IDLE: begin
          if (run) state_nxt = ADDR;
        end
        ADDR: begin
          state_nxt = WAIT;
        end
        WAIT: begin
          state_nxt = VALID;
          ir_load   = 1'b1;
          pc_nxt    = pc + PC_STEP;
        end
        VALID: begin
          if (ir_ack) state_nxt = run ? ADDR : IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      ir_out <= 16'h0000;
      pc_out <= 16'h0000;
    end else if (ir_load) begin
      ir_out <= mdr_in;
      pc_out <= pc;
    end
  end

  // The PC always names the next word to fetch, so it drives the address bus directly.
  assign addr_out = pc;
  assign memw_out = 1'b0;
  assign ir_valid = (state == VALID);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a memory model feeds mdr_in, a scoreboard predicts the
// fetched (pc, word) sequence, and directed expectations cover the corner cases.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        ir_ack = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_target = 16'h0000;
  logic [15:0] mdr_in;
  logic [15:0] addr_out, ir_out, pc_out;
  logic        memw_out, ir_valid, busy;

  logic [15:0] mdr1, addr1, ir1, pc1;
  logic        memw1, iv1, busy1;

  logic [15:0] mdr_reg = 16'h0000;
  logic [15:0] noise_val = 16'h0000;
  logic        noise = 1'b0;

  logic        pl_s = 1'b0;
  logic [15:0] pt_s = 16'h0000;
  int          rst_cnt = 0;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ir;
  } fx_t;

  typedef struct {
    int          id;
    bit          sel;
    logic [4:0]  m;
    logic [15:0] ir;
    logic [15:0] pc;
    logic [15:0] addr;
    logic        v;
    logic        b;
  } dchk_t;

  fx_t   exp_q[$];
  dchk_t dq[$];

  fetch_stage #(.RESET_PC(16'h0000), .PC_STEP(16'd2)) u0 (
    .CLK(CLK), .reset(reset), .run(run), .ir_ack(ir_ack), .pc_load(pc_load),
    .pc_target(pc_target), .mdr_in(mdr_in), .addr_out(addr_out), .memw_out(memw_out),
    .ir_out(ir_out), .pc_out(pc_out), .ir_valid(ir_valid), .busy(busy)
  );

  fetch_stage #(.RESET_PC(16'hFFFE), .PC_STEP(16'd2)) u1 (
    .CLK(CLK), .reset(reset), .run(run), .ir_ack(1'b1), .pc_load(1'b0),
    .pc_target(16'h0000), .mdr_in(mdr1), .addr_out(addr1), .memw_out(memw1),
    .ir_out(ir1), .pc_out(pc1), .ir_valid(iv1), .busy(busy1)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1234;
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Memory stage: MDR registers the word at the presented address every cycle.
  logic [15:0] mdr1_reg = 16'h0000;
  always @(posedge CLK) begin
    mdr_reg   <= mem_f(addr_out);
    mdr1_reg  <= mem_f(addr1);
    noise_val <= 16'($urandom);
  end
  assign mdr_in = noise ? noise_val : mdr_reg;
  assign mdr1   = mdr1_reg;

  always @(posedge CLK) begin
    pl_s = pc_load;
    pt_s = pc_target;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    int    last_rst;
    logic  prev_v;
    fx_t   cur;
    dchk_t d;
    last_rst = 0;
    prev_v   = 1'b0;
    cur      = '{pc: 16'h0000, ir: 16'h0000};
    forever begin
      @(negedge CLK);
      chk("memw0", {15'd0, memw_out}, 16'd0);
      chk("memw1", {15'd0, memw1}, 16'd0);
      if (reset || rst_cnt != last_rst) begin
        last_rst = rst_cnt;
        exp_q.delete();
        exp_q.push_back('{pc: 16'h0000, ir: mem_f(16'h0000)});
      end else if (pl_s) begin
        exp_q.delete();
        exp_q.push_back('{pc: pt_s, ir: mem_f(pt_s)});
        chk("redirect_valid", {15'd0, ir_valid}, 16'd0);
      end else if (ir_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL fetch_unexpected: got pc %h expected no fetch", pc_out);
        end else begin
          cur = exp_q.pop_front();
          chk("fetch_ir", ir_out, cur.ir);
          chk("fetch_pc", pc_out, cur.pc);
          exp_q.push_back('{pc: cur.pc + 16'd2, ir: mem_f(cur.pc + 16'd2)});
        end
      end else if (ir_valid) begin
        chk("hold_ir", ir_out, cur.ir);
        chk("hold_pc", pc_out, cur.pc);
      end
      prev_v = ir_valid && !reset;
      if (exp_q.size() > 0) chk("addr", addr_out, exp_q[0].pc);
      while (dq.size() > 0) begin
        d = dq.pop_front();
        if (d.m[0]) chk($sformatf("d%0d_ir", d.id), d.sel ? ir1 : ir_out, d.ir);
        if (d.m[1]) chk($sformatf("d%0d_pc", d.id), d.sel ? pc1 : pc_out, d.pc);
        if (d.m[2]) chk($sformatf("d%0d_addr", d.id), d.sel ? addr1 : addr_out, d.addr);
        if (d.m[3]) chk($sformatf("d%0d_valid", d.id), {15'd0, d.sel ? iv1 : ir_valid}, {15'd0, d.v});
        if (d.m[4]) chk($sformatf("d%0d_busy", d.id), {15'd0, d.sel ? busy1 : busy}, {15'd0, d.b});
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic dexp(input int id, input bit sel, input logic [4:0] m, input logic [15:0] ir,
                      input logic [15:0] pc, input logic [15:0] addr, input logic v, input logic b);
    dq.push_back('{id: id, sel: sel, m: m, ir: ir, pc: pc, addr: addr, v: v, b: b});
  endtask

  // Stimulus
  initial begin
    logic [15:0] t;
    repeat (3) tick();
    reset = 1'b0;
    dexp(1, 1'b0, 5'b11111, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    dexp(2, 1'b1, 5'b11111, 16'h0000, 16'h0000, 16'hFFFE, 1'b0, 1'b0);
    tick(); dexp(3, 1'b0, 5'b11000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick(); dexp(4, 1'b0, 5'b11000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);

    // First fetch: ADDR, WAIT, then VALID in the third cycle.
    run = 1'b1;
    tick(); dexp(5, 1'b0, 5'b11100, 16'h0, 16'h0, 16'h0000, 1'b0, 1'b1);
    tick(); dexp(6, 1'b0, 5'b01100, 16'h0, 16'h0, 16'h0000, 1'b0, 1'b1);
    tick();
    dexp(7, 1'b0, 5'b11111, 16'h1234, 16'h0000, 16'h0002, 1'b1, 1'b1);
    dexp(8, 1'b1, 5'b01111, mem_f(16'hFFFE), 16'hFFFE, 16'h0000, 1'b1, 1'b0);

    // Consumer stalls while the MDR churns.
    noise = 1'b1;
    repeat (5) begin
      tick(); dexp(9, 1'b0, 5'b01011, 16'h1234, 16'h0000, 16'h0, 1'b1, 1'b0);
    end
    noise  = 1'b0;
    ir_ack = 1'b1;
    tick(); dexp(10, 1'b0, 5'b11100, 16'h0, 16'h0, 16'h0002, 1'b0, 1'b1);
    ir_ack = 1'b0;

    // Redirect during WAIT discards the in-flight word.
    tick();
    pc_load = 1'b1; pc_target = 16'h00A0;
    tick(); dexp(11, 1'b0, 5'b11111, 16'h1234, 16'h0000, 16'h00A0, 1'b0, 1'b1);
    pc_load = 1'b0;
    tick(); tick();
    dexp(12, 1'b0, 5'b01111, mem_f(16'h00A0), 16'h00A0, 16'h00A2, 1'b1, 1'b0);

    // Redirect and ack together in VALID.
    pc_load = 1'b1; ir_ack = 1'b1; pc_target = 16'h0300;
    tick(); dexp(13, 1'b0, 5'b11100, 16'h0, 16'h0, 16'h0300, 1'b0, 1'b1);
    pc_load = 1'b0; ir_ack = 1'b0;
    tick(); tick();
    dexp(14, 1'b0, 5'b01111, mem_f(16'h0300), 16'h0300, 16'h0302, 1'b1, 1'b0);

    // Asynchronous reset pulse between edges while in ADDR.
    ir_ack = 1'b1;
    tick();
    ir_ack = 1'b0; run = 1'b0;
    #2;
    reset = 1'b1;
    rst_cnt++;
    #1;
    dexp(15, 1'b0, 5'b11111, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;
    tick(); dexp(16, 1'b0, 5'b11111, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick(); dexp(17, 1'b0, 5'b11100, 16'h0, 16'h0, 16'h0000, 1'b0, 1'b0);

    // Randomized traffic checked by the scoreboard.
    for (int i = 0; i < 2000; i++) begin
      run    = ($urandom_range(0, 3) != 0);
      ir_ack = ($urandom_range(0, 1) == 1);
      pc_load = ($urandom_range(0, 19) == 0);
      t = 16'($urandom) & 16'hFFFE;
      pc_target = ($urandom_range(0, 3) == 0) ? 16'hFFFE : t;
      tick();
    end
    pc_load = 1'b0;
    @(negedge CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
